// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_pkg: shared types and constants for the HI/LO multiply/divide unit.
//   muldiv_op_t : 3-bit operation code from the execute stage
//   state_t     : sequencer state, also exported on the debug state output
//   DIV_STEPS   : number of restoring-divide iterations
//   HI_RST/LO_RST : reset contents of HI and LO
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_RUN  = 2'd2,
        ST_DIV_FIX  = 2'd3
    } state_t;

    localparam int          DIV_STEPS = 32;
    localparam logic [31:0] HI_RST    = 32'h0;
    localparam logic [31:0] LO_RST    = 32'h0;

    // Magnitude of a two's-complement word; 0x8000_0000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: execute-stage request bus and HI/LO result bus.
//   OP_VALID/OP/A/B/KILL : request side, driven by the pipeline (master)
//   OP_READY/BUSY/HI/LO  : response side, driven by muldiv_ctrl (slave)
//   DBG_STATE            : sequencer state for observation only
// Handshake: a request transfers on a rising edge where OP_VALID && OP_READY
// && !KILL; the master holds OP/A/B stable while OP_VALID is high and
// OP_READY is low. OP_READY is simply !BUSY and never depends on OP_VALID.
interface muldiv_ctrl_if import muldiv_pkg::*; ();

    logic        OP_VALID;
    muldiv_op_t  OP;
    logic [31:0] A;
    logic [31:0] B;
    logic        KILL;
    logic        OP_READY;
    logic        BUSY;
    logic [31:0] HI;
    logic [31:0] LO;
    state_t      DBG_STATE;

    modport master (
        output OP_VALID, OP, A, B, KILL,
        input  OP_READY, BUSY, HI, LO, DBG_STATE
    );

    modport slave (
        input  OP_VALID, OP, A, B, KILL,
        output OP_READY, BUSY, HI, LO, DBG_STATE
    );

endinterface

// File: rtl/muldiv_ctrl_div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem_i     : partial remainder (always < divisor between steps)
//   quo_i     : quotient register; its MSB is the next dividend bit
//   divisor_i : divisor
//   rem_o/quo_o : remainder and quotient after this step
module div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shifted;
    logic [31:0] diff;
    logic        ge;

    // The shifted remainder can reach 33 bits, so the compare is 33 bits
    // wide; when it succeeds the difference is < divisor and fits in 32.
    assign shifted = {rem_i, quo_i[31]};
    assign ge      = shifted >= {1'b0, divisor_i};
    assign diff    = shifted[31:0] - divisor_i;

    always_comb begin
        rem_o = ge ? diff : shifted[31:0];
        quo_o = {quo_i[30:0], ge};
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer and owner of the HI/LO registers.
//   CLK, RESET_N : clock and asynchronous active-low reset
//   bus (slave)  : request in (OP_VALID/OP/A/B/KILL), OP_READY/BUSY/HI/LO out
// MULT/MULTU hold BUSY for MUL_LAT cycles; DIV/DIVU run 32 restoring steps
// plus one sign-fix cycle. MTHI/MTLO write in one edge without BUSY.
module muldiv_ctrl import muldiv_pkg::*; #(
    parameter int MUL_LAT = 2
) (
    input  logic         CLK,
    input  logic         RESET_N,
    muldiv_ctrl_if.slave bus
);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;     // multiplicand, or dividend/quotient
    logic [31:0] opb_q, opb_d;     // multiplier, or divisor
    logic [31:0] rem_q, rem_d;
    logic        sgn_q, sgn_d;     // signed multiply
    logic        negq_q, negq_d;   // negate quotient at fix-up
    logic        negr_q, negr_d;   // negate remainder at fix-up
    logic        dz_q, dz_d;       // divide by zero
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic signed [32:0] mul_a, mul_b;
    logic signed [63:0] prod;
    logic [31:0]        step_rem, step_quo;
    logic               accept, sdiv;

    assign mul_a = {sgn_q & opa_q[31], opa_q};
    assign mul_b = {sgn_q & opb_q[31], opb_q};
    assign prod  = 64'(mul_a) * 64'(mul_b);

    div_step u_div_step (
        .rem_i     (rem_q),
        .quo_i     (opa_q),
        .divisor_i (opb_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign accept = (state_q == ST_IDLE) && bus.OP_VALID && !bus.KILL;
    assign sdiv   = (bus.OP == OP_DIV);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (bus.OP)
                        OP_MTHI: hi_d = bus.A;
                        OP_MTLO: lo_d = bus.A;
                        OP_MULT, OP_MULTU: begin
                            opa_d   = bus.A;
                            opb_d   = bus.B;
                            sgn_d   = (bus.OP == OP_MULT);
                            cnt_d   = 5'(MUL_LAT - 1);
                            state_d = ST_MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            opa_d   = sdiv ? abs32(bus.A) : bus.A;
                            opb_d   = sdiv ? abs32(bus.B) : bus.B;
                            rem_d   = 32'h0;
                            negq_d  = sdiv && (bus.A[31] ^ bus.B[31]);
                            negr_d  = sdiv && bus.A[31];
                            dz_d    = (bus.B == 32'h0);
                            cnt_d   = 5'(DIV_STEPS - 1);
                            state_d = ST_DIV_RUN;
                        end
                        default: ;  // reserved codes: accepted, no effect
                    endcase
                end
            end
            ST_MUL_WAIT: begin
                if (bus.KILL) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 5'd0) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_DIV_RUN: begin
                if (bus.KILL) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = step_rem;
                    opa_d = step_quo;
                    if (cnt_q == 5'd0) state_d = ST_DIV_FIX;
                    else               cnt_d   = cnt_q - 5'd1;
                end
            end
            ST_DIV_FIX: begin
                if (bus.KILL) begin
                    state_d = ST_IDLE;
                end else begin
                    // Divide by zero naturally leaves HI = A (the remainder
                    // absorbs every dividend bit); only LO needs forcing.
                    // 0x8000_0000 / -1 wraps to 0x8000_0000 with no special case.
                    lo_d    = dz_q ? 32'hFFFF_FFFF : (negq_q ? -opa_q : opa_q);
                    hi_d    = negr_q ? -rem_q : rem_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            opa_q   <= 32'h0;
            opb_q   <= 32'h0;
            rem_q   <= 32'h0;
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= HI_RST;
            lo_q    <= LO_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.BUSY      = (state_q != ST_IDLE);
    assign bus.OP_READY  = (state_q == ST_IDLE);
    assign bus.HI        = hi_q;
    assign bus.LO        = lo_q;
    assign bus.DBG_STATE = state_q;

endmodule
